vmm_psum_drain: RTL and testbench
=================================

Name: vmm_psum_drain

Overview:
- Consumer at the output end of the systolic vector-matrix multiply array.
- Takes the de-skewed per-column partial sums, one Tin-chunk per valid beat, and accumulates cfg_chunks beats per output row.
- Rescales each finished row with a rounding right-shift and signed saturation, then presents it on a valid/ready stream toward the output buffer.
- The array has no stall, so this block absorbs backpressure with one output holding register and flags overruns.

Parameters:
- TOUT, 8, number of output columns (lanes).
- PSUM_DW, 20, signed width of one array lane (MAX_DW2+log2_Tin).
- ACC_DW, 32, signed accumulator width per lane.
- OUT_DW, 8, signed width of one output lane after rescale.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse; latches cfg_* and begins a job; ignored unless busy=0.
- cfg_chunks  in  16  beats per row; a value of 0 is treated as 1.
- cfg_rows  in  16  rows per job; a value of 0 is treated as 1.
- cfg_shift  in  5  arithmetic right-shift amount, 0..31.
- i_psum_vld  in  1  a partial-sum beat is present this cycle.
- i_psum  in  PSUM_DW*TOUT  signed lanes; lane k is at [k*PSUM_DW +: PSUM_DW].
- o_vld  out  1  output row valid.
- o_rdy  in  1  downstream accepts the row.
- o_dat  out  OUT_DW*TOUT  rescaled signed lanes, same packing as i_psum.
- o_last  out  1  qualifies o_vld; marks the final row of the job.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the job's last row is accepted.
- ovf_err  out  1  sticky overrun flag; cleared by cfg_start or reset.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n is asynchronous and active-low.
  - Reset values: o_vld=0, o_dat=0, o_last=0, busy=0, done=0, ovf_err=0, accumulators=0, counters=0, state IDLE.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: cfg_start latches the config, clears the accumulators, chunk_cnt, row_cnt and ovf_err, sets busy=1, and moves to RUN. i_psum_vld is ignored in IDLE.
  - RUN, on each i_psum_vld beat:
    - If chunk_cnt=0, acc[k] = sext(i_psum[k]).
    - Otherwise acc[k] = acc[k] + sext(i_psum[k]).
    - Arithmetic wraps at ACC_DW.
    - chunk_cnt increments on every beat.
  - RUN, on the beat where chunk_cnt=cfg_chunks-1 (row complete):
    - The completed sum (including the current beat) is rescaled into the holding register.
    - chunk_cnt returns to 0 and row_cnt increments.
    - If row_cnt was cfg_rows-1, the state moves to FLUSH.
- Rescale, per lane:
  - If shift=0: r = acc.
  - If shift>0: r = (acc + (1<<(shift-1))) >>> shift, computed in ACC_DW+1 bits.
  - Saturate to [-2^(OUT_DW-1), 2^(OUT_DW-1)-1].
  - Latency: o_vld rises on the cycle after the completing beat.
- Output handshake:
  - A row transfers on o_vld&o_rdy.
  - o_dat and o_last stay stable while o_vld=1 and o_rdy=0.
  - o_rdy is allowed to be high while o_vld=0.
- Overrun: a row completes while o_vld=1 and o_rdy=0.
  - Set ovf_err.
  - The new row is dropped and the held row is kept.
  - row_cnt still advances.
  - If the dropped row was the last row, o_last is forced to 1 on the held row, so that done still fires.
- Simultaneous completion and acceptance: a row completes on the same cycle the held row is accepted. This is not an overrun; the new row loads into the holding register and o_vld stays 1.
- FLUSH: wait for the o_last row to be accepted, then pulse done=1 for one cycle, set busy=0, and return to IDLE.
- cfg_start while busy=1 is ignored.
- Asserting rst_n mid-job aborts the job immediately to the reset values; no done pulse.
- i_psum_vld in FLUSH is an error: set ovf_err and discard the beat.

Test Plan:
- Basic accumulate:
  - Stimulus: chunks=3, rows=1, shift=0; lane0 beats 10, 20, -5; o_rdy=1.
  - Response: o_vld=1 one cycle after the 3rd beat; lane0=25; o_last=1; done pulses the next cycle.
- Rounding and saturation:
  - Stimulus: chunks=1, shift=4; lanes 24, -24, 5000, -5000.
  - Response: 2, -1, 127, -128.
- Backpressure without overrun:
  - Stimulus: chunks=4, rows=2; o_rdy held 0 for 3 cycles after row0 appears.
  - Response: o_dat stable while stalled; row1 delivered; ovf_err=0.
- Overrun:
  - Stimulus: chunks=1, rows=3; o_rdy=0 throughout 3 back-to-back beats of 1, 2, 3.
  - Response: ovf_err=1; the held row stays 1 with o_last=1; done pulses after o_rdy rises.
- Simultaneous completion and acceptance:
  - Stimulus: chunks=1; o_rdy pulses on exactly the beat cycle.
  - Response: no overrun; o_vld stays high; the new value appears.
- Reset mid-job and edge config:
  - Stimulus: drop rst_n during RUN.
  - Response: all outputs return to 0 and busy=0.
  - Stimulus: cfg_chunks=0 and cfg_rows=0 with one beat of 7.
  - Response: a single row of 7 with o_last=1.

Source files
------------

// File: rtl/vmm_psum_drain.sv
// Partial-sum drain for the systolic VMM array: accumulates chunk beats per row, rescales with
// rounding shift and saturation, and holds one finished row on a valid/ready output.
module vmm_psum_drain #(
   parameter int unsigned TOUT    = 8,
   parameter int unsigned PSUM_DW = 20,
   parameter int unsigned ACC_DW  = 32,
   parameter int unsigned OUT_DW  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_start,
   input  logic [15:0]             cfg_chunks,
   input  logic [15:0]             cfg_rows,
   input  logic [4:0]              cfg_shift,
   input  logic                    i_psum_vld,
   input  logic [PSUM_DW*TOUT-1:0] i_psum,
   output logic                    o_vld,
   input  logic                    o_rdy,
   output logic [OUT_DW*TOUT-1:0]  o_dat,
   output logic                    o_last,
   output logic                    busy,
   output logic                    done,
   output logic                    ovf_err
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StFlush = 2'd2;

   localparam logic signed [ACC_DW:0] SatMax = (ACC_DW+1)'(2**(OUT_DW-1) - 1);
   localparam logic signed [ACC_DW:0] SatMin = ~SatMax;

   logic [1:0]                state_q, state_d;
   logic [15:0]               chunks_q, chunks_d;
   logic [15:0]               rows_q, rows_d;
   logic [4:0]                shift_q, shift_d;
   logic [15:0]               chunk_cnt_q, chunk_cnt_d;
   logic [15:0]               row_cnt_q, row_cnt_d;
   logic signed [ACC_DW-1:0]  acc_q [TOUT];
   logic signed [ACC_DW-1:0]  acc_d [TOUT];
   logic signed [ACC_DW-1:0]  acc_sum [TOUT];
   logic [OUT_DW*TOUT-1:0]    resc_dat;
   logic                      o_vld_q, o_vld_d;
   logic [OUT_DW*TOUT-1:0]    o_dat_q, o_dat_d;
   logic                      o_last_q, o_last_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      ovf_q, ovf_d;

   logic start, run_beat, row_done, last_row, accept;

   // Rounding arithmetic shift in ACC_DW+1 bits so the rounding add cannot overflow.
   function automatic logic [OUT_DW-1:0] rescale(input logic signed [ACC_DW-1:0] a,
                                                 input logic [4:0] sh);
      logic signed [ACC_DW:0] ext;
      logic signed [ACC_DW:0] rnd;
      logic signed [ACC_DW:0] r;
      ext = {a[ACC_DW-1], a};
      rnd = '0;
      if (sh != 5'd0) rnd = (ACC_DW+1)'(1) << (sh - 5'd1);
      r = (ext + rnd) >>> sh;
      if (r > SatMax)      r = SatMax;
      else if (r < SatMin) r = SatMin;
      return r[OUT_DW-1:0];
   endfunction

   assign start    = (state_q == StIdle) && cfg_start;
   assign run_beat = (state_q == StRun) && i_psum_vld;
   assign row_done = run_beat && (chunk_cnt_q == chunks_q - 16'd1);
   assign last_row = (row_cnt_q == rows_q - 16'd1);
   assign accept   = o_vld_q && o_rdy;

   always_comb begin
      resc_dat = '0;
      for (int k = 0; k < TOUT; k++) begin
         logic signed [PSUM_DW-1:0] lane;
         lane       = i_psum[k*PSUM_DW +: PSUM_DW];
         acc_sum[k] = ((chunk_cnt_q == 16'd0) ? '0 : acc_q[k])
                      + {{(ACC_DW-PSUM_DW){lane[PSUM_DW-1]}}, lane};
         resc_dat[k*OUT_DW +: OUT_DW] = rescale(acc_sum[k], shift_q);
         if (start)         acc_d[k] = '0;
         else if (run_beat) acc_d[k] = acc_sum[k];
         else               acc_d[k] = acc_q[k];
      end
   end

   always_comb begin
      state_d     = state_q;
      chunks_d    = chunks_q;
      rows_d      = rows_q;
      shift_d     = shift_q;
      chunk_cnt_d = chunk_cnt_q;
      row_cnt_d   = row_cnt_q;
      o_vld_d     = o_vld_q;
      o_dat_d     = o_dat_q;
      o_last_d    = o_last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ovf_d       = ovf_q;
      case (state_q)
         StIdle: begin
            if (cfg_start) begin
               chunks_d    = (cfg_chunks == 16'd0) ? 16'd1 : cfg_chunks;
               rows_d      = (cfg_rows == 16'd0) ? 16'd1 : cfg_rows;
               shift_d     = cfg_shift;
               chunk_cnt_d = '0;
               row_cnt_d   = '0;
               ovf_d       = 1'b0;
               busy_d      = 1'b1;
               state_d     = StRun;
            end
         end
         StRun: begin
            if (accept) begin
               o_vld_d  = 1'b0;
               o_last_d = 1'b0;
            end
            if (i_psum_vld) begin
               if (row_done) begin
                  chunk_cnt_d = '0;
                  row_cnt_d   = row_cnt_q + 16'd1;
                  if (o_vld_q && !o_rdy) begin
                     // Overrun: keep the held row, but make sure it still closes the job.
                     ovf_d = 1'b1;
                     if (last_row) o_last_d = 1'b1;
                  end else begin
                     o_vld_d  = 1'b1;
                     o_dat_d  = resc_dat;
                     o_last_d = last_row;
                  end
                  if (last_row) state_d = StFlush;
               end else begin
                  chunk_cnt_d = chunk_cnt_q + 16'd1;
               end
            end
         end
         StFlush: begin
            if (i_psum_vld) ovf_d = 1'b1;
            if (accept) begin
               o_vld_d  = 1'b0;
               o_last_d = 1'b0;
               if (o_last_q) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         chunks_q    <= '0;
         rows_q      <= '0;
         shift_q     <= '0;
         chunk_cnt_q <= '0;
         row_cnt_q   <= '0;
         o_vld_q     <= 1'b0;
         o_dat_q     <= '0;
         o_last_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         for (int k = 0; k < TOUT; k++) acc_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         chunks_q    <= chunks_d;
         rows_q      <= rows_d;
         shift_q     <= shift_d;
         chunk_cnt_q <= chunk_cnt_d;
         row_cnt_q   <= row_cnt_d;
         o_vld_q     <= o_vld_d;
         o_dat_q     <= o_dat_d;
         o_last_q    <= o_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         for (int k = 0; k < TOUT; k++) acc_q[k] <= acc_d[k];
      end
   end

   assign o_vld   = o_vld_q;
   assign o_dat   = o_dat_q;
   assign o_last  = o_last_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ovf_err = ovf_q;

endmodule

// File: tb/tb_vmm_psum_drain.sv
// Directed self-checking bench for vmm_psum_drain using immediate assertions.
module tb_vmm_psum_drain;

   localparam int TOUT    = 8;
   localparam int PSUM_DW = 20;
   localparam int OUT_DW  = 8;

   logic                    clk;
   logic                    rst_n;
   logic                    cfg_start;
   logic [15:0]             cfg_chunks;
   logic [15:0]             cfg_rows;
   logic [4:0]              cfg_shift;
   logic                    i_psum_vld;
   logic [PSUM_DW*TOUT-1:0] i_psum;
   logic                    o_vld;
   logic                    o_rdy;
   logic [OUT_DW*TOUT-1:0]  o_dat;
   logic                    o_last;
   logic                    busy;
   logic                    done;
   logic                    ovf_err;

   int n_chk  = 0;
   int n_fail = 0;

   vmm_psum_drain dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_start  (cfg_start),
      .cfg_chunks (cfg_chunks),
      .cfg_rows   (cfg_rows),
      .cfg_shift  (cfg_shift),
      .i_psum_vld (i_psum_vld),
      .i_psum     (i_psum),
      .o_vld      (o_vld),
      .o_rdy      (o_rdy),
      .o_dat      (o_dat),
      .o_last     (o_last),
      .busy       (busy),
      .done       (done),
      .ovf_err    (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int c, input int r, input int s);
      cfg_chunks = 16'(c);
      cfg_rows   = 16'(r);
      cfg_shift  = 5'(s);
      cfg_start  = 1'b1;
      tick();
      cfg_start  = 1'b0;
   endtask

   // One beat with lanes 0..3 driven, remaining lanes zero.
   task automatic beat4(input int v0, input int v1, input int v2, input int v3);
      i_psum = '0;
      i_psum[0*PSUM_DW +: PSUM_DW] = PSUM_DW'(v0);
      i_psum[1*PSUM_DW +: PSUM_DW] = PSUM_DW'(v1);
      i_psum[2*PSUM_DW +: PSUM_DW] = PSUM_DW'(v2);
      i_psum[3*PSUM_DW +: PSUM_DW] = PSUM_DW'(v3);
      i_psum_vld = 1'b1;
      tick();
      i_psum_vld = 1'b0;
   endtask

   task automatic beat(input int v0);
      beat4(v0, 0, 0, 0);
   endtask

   function automatic logic [63:0] lane0(input int v);
      logic [63:0] e;
      e = '0;
      e[7:0] = 8'(v);
      return e;
   endfunction

   initial begin
      rst_n = 1'b0; cfg_start = 1'b0; cfg_chunks = '0; cfg_rows = '0; cfg_shift = '0;
      i_psum_vld = 1'b0; i_psum = '0; o_rdy = 1'b0;
      tick(); tick();
      check("rst_outs", {59'd0, o_vld, o_last, busy, done, ovf_err}, 64'd0);
      check("rst_dat", o_dat, 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic accumulate
      start(3, 1, 0);
      check("basic_busy", {63'd0, busy}, 64'd1);
      o_rdy = 1'b1;
      beat(10);
      beat(20);
      check("basic_novld", {63'd0, o_vld}, 64'd0);
      beat(-5);
      check("basic_vld", {62'd0, o_vld, o_last}, 64'd3);
      check("basic_dat", o_dat, lane0(25));
      tick();
      check("basic_done", {62'd0, done, busy}, 64'd2);
      tick();
      check("basic_done_pulse", {63'd0, done}, 64'd0);

      // Rounding and saturation
      start(1, 1, 4);
      beat4(24, -24, 5000, -5000);
      check("round_dat", o_dat, 64'h0000_0000_807F_FF02);
      tick();
      check("round_done", {63'd0, done}, 64'd1);

      // Backpressure without overrun
      start(4, 2, 0);
      o_rdy = 1'b0;
      beat(1); beat(2); beat(3); beat(4);
      check("bp_row0", {o_vld, o_last, o_dat[61:0]}, {2'b10, lane0(10)[61:0]});
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_stable", {o_vld, o_last, o_dat[61:0]}, {2'b10, lane0(10)[61:0]});
      end
      o_rdy = 1'b1;
      tick();
      check("bp_accept", {63'd0, o_vld}, 64'd0);
      beat(5); beat(5); beat(5); beat(5);
      check("bp_row1", {o_vld, o_last, o_dat[61:0]}, {2'b11, lane0(20)[61:0]});
      tick();
      check("bp_done_noovf", {62'd0, done, ovf_err}, 64'd2);

      // Overrun
      start(1, 3, 0);
      o_rdy = 1'b0;
      beat(1);
      check("ovr_row0", {o_vld, o_last, o_dat[61:0]}, {2'b10, lane0(1)[61:0]});
      beat(2);
      check("ovr_flag", {62'd0, ovf_err, o_vld}, 64'd3);
      check("ovr_hold", o_dat, lane0(1));
      beat(3);
      check("ovr_last", {o_vld, o_last, o_dat[61:0]}, {2'b11, lane0(1)[61:0]});
      check("ovr_busy", {63'd0, busy}, 64'd1);
      o_rdy = 1'b1;
      tick();
      check("ovr_done", {61'd0, done, busy, ovf_err}, 64'b101);

      // Simultaneous completion and acceptance
      start(1, 2, 0);
      o_rdy = 1'b0;
      beat(3);
      check("sim_row0", o_dat, lane0(3));
      o_rdy = 1'b1;
      beat(9);
      check("sim_row1", {o_vld, o_last, o_dat[61:0]}, {2'b11, lane0(9)[61:0]});
      check("sim_noovf", {63'd0, ovf_err}, 64'd0);
      tick();
      check("sim_done", {63'd0, done}, 64'd1);

      // Reset mid-job
      start(1, 2, 0);
      o_rdy = 1'b0;
      beat(4);
      check("mid_pre", {62'd0, o_vld, busy}, 64'd3);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_outs", {59'd0, o_vld, o_last, busy, done, ovf_err}, 64'd0);
      check("mid_rst_dat", o_dat, 64'd0);
      rst_n = 1'b1;
      tick();
      check("mid_rst_after", {62'd0, busy, done}, 64'd0);

      // Zero config treated as one chunk / one row
      start(0, 0, 0);
      o_rdy = 1'b1;
      beat(7);
      check("zcfg_row", {o_vld, o_last, o_dat[61:0]}, {2'b11, lane0(7)[61:0]});
      tick();
      check("zcfg_done", {62'd0, done, busy}, 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
